// File: rtl/dmem_banked_ctrl_pkg.sv
// Shared control codes for the banked data memory: RV32 funct3 load/store codes,
// access error codes, FSM states and the decode/extension helpers.
package dmem_banked_ctrl_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_TYPE     = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // One accepted request travelling from the RAM read edge to the response
  typedef struct packed {
    logic       valid;
    logic       load;
    logic [1:0] err;
    logic [1:0] off;
    logic [2:0] f3;
  } s1_t;

  // Type fault outranks misalignment, which outranks range
  function automatic logic [1:0] decode_err(input logic we, input logic [2:0] f3,
                                            input logic [1:0] lo, input logic range_bad);
    logic legal;
    logic misal;
    legal = we ? (f3 inside {F3_B, F3_H, F3_W})
               : (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    misal = ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    if (!legal)        return ERR_TYPE;
    else if (misal)    return ERR_MISALIGN;
    else if (range_bad) return ERR_RANGE;
    else               return ERR_NONE;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    return {{24{b[7]}}, b};
      F3_BU:   return {24'h000000, b};
      F3_H:    return {{16{h[15]}}, h};
      F3_HU:   return {16'h0000, h};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bytelane_ram.sv
// Single-port word RAM built from four byte-lane arrays; per-lane write strobe,
// registered read, no reset on the storage.
module dmem_bytelane_ram #(
  parameter int DMEM_DEPTH = 4096,
  parameter int AW         = $clog2(DMEM_DEPTH)
) (
  input  logic          CPU_clk,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_mem [DMEM_DEPTH];
      logic [7:0] lane_rd_reg;

      always_ff @(posedge CPU_clk) begin
        if (be[gi]) lane_mem[addr] <= wdata[gi*8 +: 8];
        lane_rd_reg <= lane_mem[addr];
      end

      assign rdata[gi*8 +: 8] = lane_rd_reg;
    end
  endgenerate

endmodule

// File: rtl/dmem_banked_ctrl.sv
// Banked data memory controller: zero sweep after reset, valid/ready requests,
// byte-strobe stores, extended loads and fixed-latency responses with fault codes.
module dmem_banked_ctrl
  import dmem_banked_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DMEM_DEPTH = 4096,
  parameter int RD_LATENCY = 1
) (
  input  logic             CPU_clk,
  input  logic             CPU_rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [2:0]       req_type,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic [1:0]       rsp_err_code,
  output logic             init_done
);

  localparam int AW         = $clog2(DMEM_DEPTH);
  localparam int BYTE_RANGE = AW + 2;

  state_t        state_reg;
  logic [AW-1:0] cnt_reg;
  logic          req_ready_reg;
  logic          init_done_reg;

  logic          accept;
  logic [1:0]    err_next;
  logic [AW-1:0] ram_addr;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  s1_t           s1_next;
  s1_t           s1_reg;
  logic [31:0]   ext_data;

  always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
    if (!CPU_rst_n) begin
      state_reg     <= ST_INIT;
      cnt_reg       <= '0;
      req_ready_reg <= 1'b0;
      init_done_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_INIT: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == AW'(DMEM_DEPTH - 1)) begin
            state_reg     <= ST_RUN;
            req_ready_reg <= 1'b1;
            init_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= ST_RUN;
          req_ready_reg <= 1'b1;
          init_done_reg <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_reg;
  assign init_done = init_done_reg;
  assign accept    = req_valid && req_ready_reg;
  assign err_next  = decode_err(req_we, req_type, req_addr[1:0],
                                |req_addr[WIDTH-1:BYTE_RANGE]);

  // The sweep owns the single RAM port until the FSM reaches RUN
  always_comb begin
    ram_addr  = cnt_reg;
    ram_be    = 4'b1111;
    ram_wdata = '0;
    if (state_reg == ST_RUN) begin
      ram_addr = req_addr[BYTE_RANGE-1:2];
      ram_be   = 4'b0000;
      if (accept && req_we && (err_next == ERR_NONE)) begin
        case (req_type)
          F3_B: begin
            ram_be    = 4'b0001 << req_addr[1:0];
            ram_wdata = {4{req_wdata[7:0]}};
          end
          F3_H: begin
            ram_be    = req_addr[1] ? 4'b1100 : 4'b0011;
            ram_wdata = {2{req_wdata[15:0]}};
          end
          default: begin
            ram_be    = 4'b1111;
            ram_wdata = req_wdata[31:0];
          end
        endcase
      end
    end
  end

  dmem_bytelane_ram #(
    .DMEM_DEPTH (DMEM_DEPTH),
    .AW         (AW)
  ) u_ram (
    .CPU_clk (CPU_clk),
    .addr    (ram_addr),
    .be      (ram_be),
    .wdata   (ram_wdata),
    .rdata   (ram_rdata)
  );

  always_comb begin
    s1_next       = '0;
    s1_next.valid = accept;
    s1_next.load  = accept && !req_we && (err_next == ERR_NONE);
    s1_next.err   = accept ? err_next : ERR_NONE;
    s1_next.off   = req_addr[1:0];
    s1_next.f3    = req_type;
  end

  always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
    if (!CPU_rst_n) s1_reg <= '0;
    else            s1_reg <= s1_next;
  end

  assign ext_data = s1_reg.load ? load_extend(ram_rdata, s1_reg.off, s1_reg.f3) : 32'h0;

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic        rsp_valid_reg;
      logic [31:0] rsp_rdata_reg;
      logic        rsp_err_reg;
      logic [1:0]  rsp_code_reg;

      always_ff @(posedge CPU_clk or negedge CPU_rst_n) begin
        if (!CPU_rst_n) begin
          rsp_valid_reg <= 1'b0;
          rsp_rdata_reg <= '0;
          rsp_err_reg   <= 1'b0;
          rsp_code_reg  <= ERR_NONE;
        end else begin
          rsp_valid_reg <= s1_reg.valid;
          rsp_rdata_reg <= ext_data;
          rsp_err_reg   <= (s1_reg.err != ERR_NONE);
          rsp_code_reg  <= s1_reg.err;
        end
      end

      assign rsp_valid    = rsp_valid_reg;
      assign rsp_rdata    = WIDTH'(rsp_rdata_reg);
      assign rsp_err      = rsp_err_reg;
      assign rsp_err_code = rsp_code_reg;
    end else begin : g_lat1
      assign rsp_valid    = s1_reg.valid;
      assign rsp_rdata    = WIDTH'(ext_data);
      assign rsp_err      = (s1_reg.err != ERR_NONE);
      assign rsp_err_code = s1_reg.err;
    end
  endgenerate

endmodule

// File: tb/tb_dmem_banked_ctrl.sv
// Randomised and directed bench for dmem_banked_ctrl against a byte-addressed
// reference memory with a cycle-scheduled response table.
module tb_dmem_banked_ctrl;

  localparam int DEPTH = 4096;
  localparam int LAT   = 2;
  localparam int NBYTE = 4 * DEPTH;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  code;
  } exp_t;

  logic        CPU_clk = 1'b0;
  logic        CPU_rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_type = 3'b010;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  rsp_err_code;
  logic        init_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rel = 0;
  logic [7:0] mb [NBYTE];
  exp_t sched [int];
  exp_t cap_q [$];

  always #5 CPU_clk = ~CPU_clk;

  dmem_banked_ctrl #(.WIDTH(32), .DMEM_DEPTH(DEPTH), .RD_LATENCY(LAT)) dut (
    .CPU_clk      (CPU_clk),
    .CPU_rst_n    (CPU_rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_type     (req_type),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .rsp_err_code (rsp_err_code),
    .init_done    (init_done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: byte-addressed little-endian memory, faults from the access rules
  task automatic model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output exp_t r);
    int size;
    logic [31:0] v;
    r = '0;
    case (f3)
      3'b000, 3'b100: size = 1;
      3'b001, 3'b101: size = 2;
      3'b010:         size = 4;
      default:        size = 0;
    endcase
    if (size == 0 || (we && f3[2])) begin
      r.err = 1'b1; r.code = 2'b11;
    end else if ((addr % size) != 0) begin
      r.err = 1'b1; r.code = 2'b01;
    end else if (addr >= 32'(NBYTE)) begin
      r.err = 1'b1; r.code = 2'b10;
    end else if (we) begin
      for (int i = 0; i < size; i++) mb[int'(addr) + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v[8*i +: 8] = mb[int'(addr) + i];
      if (!f3[2] && size < 4 && v[8*size-1])
        for (int j = size; j < 4; j++) v[8*j +: 8] = 8'hFF;
      r.rdata = v;
    end
  endtask

  always @(posedge CPU_clk) begin
    exp_t r;
    cyc++;
    if (!CPU_rst_n) begin
      if (rel != 0 || sched.size() != 0) sched.delete();
      rel = 0;
      for (int i = 0; i < NBYTE; i++) mb[i] = 8'h00;
    end else begin
      if (req_valid && rel >= DEPTH) begin
        model_req(req_we, req_type, req_addr, req_wdata, r);
        sched[cyc + LAT - 1] = r;
      end
      rel++;
    end
  end

  always @(negedge CPU_clk) begin
    exp_t e;
    if (!CPU_rst_n) begin
      sched.delete(cyc);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_rsp_fields", {rsp_rdata, rsp_err, rsp_err_code}, 0);
    end else begin
      chk("req_ready", req_ready, rel >= DEPTH);
      chk("init_done", init_done, rel >= DEPTH);
      if (sched.exists(cyc)) begin
        e = sched[cyc];
        sched.delete(cyc);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_err_code", rsp_err_code, e.code);
        $display("RSP cyc=%0d rdata=%08h err=%0d code=%0d", cyc, rsp_rdata, rsp_err, rsp_err_code);
      end else begin
        chk("rsp_valid_idle", rsp_valid, 0);
        chk("rsp_idle_zero", {rsp_rdata, rsp_err, rsp_err_code}, 0);
      end
      if (rsp_valid) cap_q.push_back('{rsp_rdata, rsp_err, rsp_err_code});
    end
  end

  task automatic step();
    @(posedge CPU_clk);
    #1;
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wd);
    req_valid = 1'b1; req_we = we; req_type = f3; req_addr = addr; req_wdata = wd;
    step();
  endtask

  task automatic drain();
    req_valid = 1'b0;
    repeat (LAT + 2) step();
  endtask

  task automatic cap(input string nm, input int i, input logic [31:0] rd, input logic [1:0] code);
    if (i < cap_q.size()) begin
      chk(nm, {cap_q[i].rdata, cap_q[i].err, cap_q[i].code}, {rd, code != 2'b00, code});
    end else begin
      chk({nm, "_missing"}, cap_q.size(), i + 1);
    end
  endtask

  task automatic wait_init(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge CPU_clk);
      n++;
      @(negedge CPU_clk);
    end while (!init_done && n < DEPTH + 20);
    chk(nm, n, DEPTH);
  endtask

  initial begin
    repeat (3) step();
    CPU_rst_n = 1'b1;
    wait_init("init_cycles");
    step();

    cap_q.delete();
    req(0, 3'b010, 32'h000, 0);
    drain();
    chk("lw0_count", cap_q.size(), 1);
    cap("lw0_zero", 0, 32'h0, 2'b00);

    cap_q.delete();
    req(1, 3'b010, 32'h010, 32'hDEADBEEF);
    req(0, 3'b000, 32'h013, 0);
    req(0, 3'b100, 32'h013, 0);
    req(0, 3'b001, 32'h012, 0);
    req(0, 3'b101, 32'h010, 0);
    drain();
    cap("sw_rsp", 0, 32'h0, 2'b00);
    cap("lb_13", 1, 32'hFFFFFFDE, 2'b00);
    cap("lbu_13", 2, 32'h000000DE, 2'b00);
    cap("lh_12", 3, 32'hFFFFDEAD, 2'b00);
    cap("lhu_10", 4, 32'h0000BEEF, 2'b00);

    cap_q.delete();
    req(1, 3'b010, 32'h020, 32'h11223344);
    req(1, 3'b000, 32'h021, 32'h0000005A);
    req(0, 3'b010, 32'h020, 0);
    req(1, 3'b001, 32'h022, 32'h0000ABCD);
    req(0, 3'b010, 32'h020, 0);
    drain();
    cap("sb_merge", 2, 32'h11225A44, 2'b00);
    cap("sh_merge", 4, 32'hABCD5A44, 2'b00);

    cap_q.delete();
    req(1, 3'b010, 32'h030, 32'hCAFEF00D);
    req(1, 3'b001, 32'h031, 32'h00001234);
    req(0, 3'b010, 32'h032, 0);
    req(0, 3'b010, 32'h00010000, 0);
    req(0, 3'b011, 32'h000, 0);
    req(1, 3'b100, 32'h030, 32'h0);
    req(0, 3'b011, 32'h00010001, 0);
    req(0, 3'b010, 32'h00010001, 0);
    req(0, 3'b010, 32'h030, 0);
    drain();
    cap("sh_misalign", 1, 32'h0, 2'b01);
    cap("lw_misalign", 2, 32'h0, 2'b01);
    cap("lw_range", 3, 32'h0, 2'b10);
    cap("ld_type", 4, 32'h0, 2'b11);
    cap("st_type", 5, 32'h0, 2'b11);
    cap("prio_type", 6, 32'h0, 2'b11);
    cap("prio_misal", 7, 32'h0, 2'b01);
    cap("word_kept", 8, 32'hCAFEF00D, 2'b00);

    cap_q.delete();
    req_valid = 1'b1; req_we = 1'b0; req_type = 3'b010; req_addr = 32'h010;
    @(posedge CPU_clk); #1;
    req_addr = 32'h020;
    @(posedge CPU_clk); #1;
    CPU_rst_n = 1'b0;
    req_valid = 1'b0;
    repeat (3) step();
    chk("rst_no_rsp", cap_q.size(), 0);
    CPU_rst_n = 1'b1;
    req_valid = 1'b1; req_addr = 32'h010;
    wait_init("reinit_cycles");
    @(posedge CPU_clk); #1;
    req_valid = 1'b0;
    req(0, 3'b010, 32'h020, 0);
    drain();
    chk("reinit_count", cap_q.size(), 2);
    cap("reinit_10", 0, 32'h0, 2'b00);
    cap("reinit_20", 1, 32'h0, 2'b00);

    for (int k = 0; k < 400; k++) begin
      logic [31:0] a;
      logic [2:0]  f;
      logic        w;
      case ($urandom % 8)
        0, 1, 2, 3, 4, 5: a = $urandom % 64;
        6:                a = $urandom % NBYTE;
        default:          a = $urandom;
      endcase
      w = 1'($urandom % 2);
      f = ($urandom % 4 == 0) ? 3'($urandom % 8) : (w ? 3'($urandom % 3) : 3'($urandom % 6));
      if ($urandom % 4 == 0) begin
        req_valid = 1'b0;
        step();
      end else begin
        req(w, f, a, $urandom);
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_banked_ctrl.md
Name: dmem_banked_ctrl

Overview:
Parametrised successor to the single-cycle data memory, built for the pipelined RV32IM core.
- Fronts a word-organised, byte-laned synchronous RAM with a valid/ready request channel and a fixed-latency response channel.
- Adds a post-reset zero-initialisation sweep, byte-strobe writes, and a selectable 1- or 2-cycle read latency.
- Reports misaligned, out-of-range and illegal-type accesses as errors instead of silently NOPing them.

Parameters:
WIDTH, 32, data/address width in bits; only 32 is supported.
DMEM_DEPTH, 4096, number of words; must be a power of two.
RD_LATENCY, 1, cycles from request acceptance to rsp_valid; legal values are 1 and 2.

Ports:
CPU_clk  input  1  single clock, rising edge
CPU_rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  block can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_type  input  3  RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
req_addr  input  WIDTH  byte address
req_wdata  input  WIDTH  store data, right-aligned
rsp_valid  output  1  response present (1-cycle pulse per request)
rsp_rdata  output  WIDTH  load data, extended per req_type; 0 for stores and errors
rsp_err  output  1  access faulted
rsp_err_code  output  2  00 ok, 01 misaligned, 10 out-of-range, 11 illegal type
init_done  output  1  high once the zero sweep completes

Behaviour:
- Clock and reset: single clock CPU_clk; asynchronous active-low reset CPU_rst_n.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_err_code=00, init_done=0. The FSM enters INIT with the sweep counter at 0.
- FSM state INIT: writes 0 to word[cnt] each cycle, cnt = 0..DMEM_DEPTH-1, with req_ready=0. On the cycle after cnt=DMEM_DEPTH-1 is written, the FSM moves to RUN and init_done=1. INIT takes exactly DMEM_DEPTH cycles.
- FSM state RUN: req_ready=1 permanently; one request is accepted per cycle (no backpressure from the response side).
- Acceptance is req_valid && req_ready. Requests presented during INIT are not accepted and must be held by the master.
- Decode happens in the acceptance cycle; BYTE_RANGE = log2(4*DMEM_DEPTH).
  - Illegal type: a load with req_type in {011,110,111}, or a store with req_type other than {000,001,010} -> code 11.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0 -> code 01.
  - Out-of-range: addr[WIDTH-1:BYTE_RANGE] != 0 -> code 10.
  - Priority is 11 > 01 > 10.
- On any error: no RAM write, rsp_rdata=0, rsp_err=1.
- Stores: the write is committed at the acceptance edge using 4-bit byte strobes.
  - SB: strobe = 1<<addr[1:0], data lane = wdata[7:0] replicated.
  - SH: strobe = 0011 or 1100 by addr[1].
  - SW: strobe = 1111.
  - A store response is rsp_valid with rdata=0 and err=0 after RD_LATENCY cycles.
- Loads: the RAM is read synchronously at the acceptance edge.
  - Byte-lane selection and extension use the registered addr[1:0] and type: LB/LH sign-extend, LBU/LHU zero-extend.
  - RD_LATENCY=2 adds one output register stage after extension.
- Ordering: responses return in request order at fixed latency.
  - A load accepted the cycle after a store to the same word returns the new data; no forwarding is needed because the write is committed at the earlier edge.
  - Back-to-back requests yield back-to-back rsp_valid.
- rsp_* outputs are held at zero when rsp_valid=0.
- Reset asserted mid-operation: in-flight responses are discarded and no rsp_valid is emitted. The FSM returns to INIT and the RAM is re-zeroed. A partially swept RAM is never exposed.

Decomposition:
- Shared package/header (extends the existing CPU control-codes include): funct3 load/store codes, err_code constants (ERR_NONE, ERR_MISALIGN, ERR_RANGE, ERR_TYPE), FSM state encodings.
- One sub-module, dmem_bytelane_ram: DMEM_DEPTH x 32 synchronous RAM with 4-bit write strobe, single port, registered read, no reset on the array.

Test Plan:
- Reset then idle: init_done rises exactly DMEM_DEPTH cycles after CPU_rst_n deasserts, with req_ready=0 throughout; a subsequent LW of 0x000 returns 0x00000000.
- SW 0xDEADBEEF @0x010, then LB @0x013, LBU @0x013, LH @0x012, LHU @0x010 back-to-back: responses are 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF, each RD_LATENCY cycles after its request.
- SB 0x5A @0x021 over word 0x11223344: a following LW @0x020 returns 0x11225A44. SH 0xABCD @0x022 then gives 0xABCD5A44.
- SH @0x031 and LW @0x032: rsp_err=1, code 01, rdata=0, and the memory word is unchanged.
- LW @0x00010000 with DMEM_DEPTH=4096 -> code 10. Load with req_type 011 -> code 11. Store with req_type 100 -> code 11, no write.
- Assert CPU_rst_n low with two loads in flight (RD_LATENCY=2): no rsp_valid appears; after release the INIT sweep restarts and previously written data reads back 0.
